// File: rtl/bip_acc_bank.sv
// bip_acc_bank: registered accumulator bank and operand-B pipeline stage
// for the BIP datapath. NUM_ACC clocked accumulators with a source mux,
// immediate sign extension, an issue/stall handshake and registered Z/N flags.
// Optional build macro: ACC_BYPASS_EN (write-through forwarding on o_ACC).
module bip_acc_bank #(
  parameter int NBITS_D = 16,
  parameter int NBITS_O = 11,
  parameter int NUM_ACC = 4,
  parameter int IDX_W   = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [IDX_W-1:0]   i_rd_idx,
  input  logic [1:0]         i_SelA,
  input  logic               i_SelB,
  input  logic               i_WrAcc,
  input  logic [NBITS_O-1:0] i_Operand,
  input  logic [NBITS_D-1:0] i_OutData,
  input  logic [NBITS_D-1:0] i_ALU,
  output logic [NBITS_D-1:0] o_ACC,
  output logic [NBITS_D-1:0] o_SelB,
  output logic               o_valid,
  output logic               o_zero,
  output logic               o_neg
);

  // Widen the immediate keeping its sign; a signed cast extends from the MSB.
  function automatic logic signed [NBITS_D-1:0] sign_ext(input logic signed [NBITS_O-1:0] op);
    return NBITS_D'(op);
  endfunction

  logic signed [NBITS_D-1:0] acc_p1 [NUM_ACC];
  logic signed [NBITS_D-1:0] sel_b_p1;
  logic                      vld_p1;
  logic                      zero_p1;
  logic                      neg_p1;

  logic signed [NBITS_D-1:0] ext_p0;
  logic signed [NBITS_D-1:0] wdata_p0;
  logic signed [NBITS_D-1:0] bsel_p0;
  logic signed [NBITS_D-1:0] rd_data;
  logic                      we_p0;

  // Stage p0: operand selection and write qualification (combinational)
  always_comb begin
    ext_p0   = sign_ext(i_Operand);
    we_p0    = i_valid & i_WrAcc & ~i_stall & (i_SelA != 2'b11);
    bsel_p0  = i_SelB ? ext_p0 : signed'(i_OutData);
    wdata_p0 = '0;
    case (i_SelA)
      2'b00:   wdata_p0 = signed'(i_OutData);
      2'b01:   wdata_p0 = ext_p0;
      2'b10:   wdata_p0 = signed'(i_ALU);
      default: wdata_p0 = '0;
    endcase
  end

  // Stage p1: accumulator bank, written only on a qualified issue
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_ACC; i++) acc_p1[i] <= '0;
    end else if (we_p0) begin
      acc_p1[i_wr_idx] <= wdata_p0;
    end
  end

  // Stage p1: Z/N flags track the most recent accumulator write
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      zero_p1 <= 1'b0;
      neg_p1  <= 1'b0;
    end else if (we_p0) begin
      zero_p1 <= (wdata_p0 == '0);
      neg_p1  <= wdata_p0[NBITS_D-1];
    end
  end

  // Stage p1: operand-B register; a stall freezes it and drops the issue
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sel_b_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (!i_stall) begin
      vld_p1 <= i_valid;
      if (i_valid) sel_b_p1 <= bsel_p0;
    end
  end

  // Read port: register array, optionally forwarding a same-cycle write
  always_comb begin
`ifdef ACC_BYPASS_EN
    if (we_p0 && (i_rd_idx == i_wr_idx)) rd_data = wdata_p0;
    else                                 rd_data = acc_p1[i_rd_idx];
`else
    rd_data = acc_p1[i_rd_idx];
`endif
  end

  assign o_ACC   = rd_data;
  assign o_SelB  = sel_b_p1;
  assign o_valid = vld_p1;
  assign o_zero  = zero_p1;
  assign o_neg   = neg_p1;

endmodule

// File: tb/tb_bip_acc_bank.sv
// Self-checking bench for bip_acc_bank (default parameters). A reference
// model tracks the accumulators and flags; issued operand-B values go into a
// scoreboard queue and are compared when the DUT presents them.
module tb_bip_acc_bank;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_stall, i_SelB, i_WrAcc;
  logic [1:0]  i_wr_idx, i_rd_idx, i_SelA;
  logic [10:0] i_Operand;
  logic [15:0] i_OutData, i_ALU;
  logic [15:0] o_ACC, o_SelB;
  logic        o_valid, o_zero, o_neg;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] sb_q[$];
  logic [15:0] m_acc [4];
  logic [15:0] m_selb;
  logic        m_vld, m_z, m_n;

  always #5 i_clk = ~i_clk;

  bip_acc_bank #(.NBITS_D(16), .NBITS_O(11), .NUM_ACC(4), .IDX_W(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
    .i_wr_idx(i_wr_idx), .i_rd_idx(i_rd_idx), .i_SelA(i_SelA), .i_SelB(i_SelB),
    .i_WrAcc(i_WrAcc), .i_Operand(i_Operand), .i_OutData(i_OutData), .i_ALU(i_ALU),
    .o_ACC(o_ACC), .o_SelB(o_SelB), .o_valid(o_valid), .o_zero(o_zero), .o_neg(o_neg)
  );

  function automatic logic [15:0] ext16(input logic [10:0] op);
    return {{5{op[10]}}, op};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic rst, input logic vld, input logic stl,
                        input logic [1:0] wr, input logic [1:0] rd, input logic [1:0] sa,
                        input logic sb, input logic wacc, input logic [10:0] op,
                        input logic [15:0] od, input logic [15:0] alu);
    i_reset = rst; i_valid = vld; i_stall = stl; i_wr_idx = wr; i_rd_idx = rd;
    i_SelA = sa; i_SelB = sb; i_WrAcc = wacc; i_Operand = op; i_OutData = od; i_ALU = alu;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 2'd0, i_rd_idx, 2'b11, 1'b0, 1'b0, 11'h0, 16'h0, 16'h0);
  endtask

  // One clock: check the read port before the edge, advance the model, check after.
  task automatic tick();
    logic        we, pushed;
    logic [15:0] wd, bsel, exp_acc, exp_b;
    #2;
    we = i_valid & i_WrAcc & ~i_stall & (i_SelA != 2'b11);
    case (i_SelA)
      2'b00:   wd = i_OutData;
      2'b01:   wd = ext16(i_Operand);
      2'b10:   wd = i_ALU;
      default: wd = 16'h0;
    endcase
    exp_acc = m_acc[i_rd_idx];
`ifdef ACC_BYPASS_EN
    if (we && (i_rd_idx == i_wr_idx)) exp_acc = wd;
`endif
    chk("acc_rd", o_ACC, exp_acc);
    bsel   = i_SelB ? ext16(i_Operand) : i_OutData;
    pushed = 1'b0;
    if (i_reset) begin
      for (int i = 0; i < 4; i++) m_acc[i] = 16'h0;
      m_selb = 16'h0; m_vld = 1'b0; m_z = 1'b0; m_n = 1'b0;
      sb_q.delete();
    end else begin
      if (we) begin
        m_acc[i_wr_idx] = wd;
        m_z = (wd == 16'h0);
        m_n = wd[15];
      end
      if (!i_stall) begin
        m_vld = i_valid;
        if (i_valid) begin
          sb_q.push_back(bsel);
          m_selb = bsel;
          pushed = 1'b1;
        end
      end
    end
    @(posedge i_clk);
    #1;
    chk("valid", {15'h0, o_valid}, {15'h0, m_vld});
    chk("zero", {15'h0, o_zero}, {15'h0, m_z});
    chk("neg", {15'h0, o_neg}, {15'h0, m_n});
    if (pushed) begin
      if (sb_q.size() == 0) chk("sb_empty", 16'h1, 16'h0);
      else begin
        exp_b = sb_q.pop_front();
        chk("selb_issue", o_SelB, exp_b);
      end
    end else begin
      chk("selb_hold", o_SelB, m_selb);
    end
  endtask

  task automatic chk_acc(input logic [1:0] idx, input logic [15:0] exp, input string tag);
    i_valid = 1'b0;
    i_rd_idx = idx;
    #1;
    chk(tag, o_ACC, exp);
  endtask

  task automatic chk_all_model();
    for (int i = 0; i < 4; i++) chk_acc(2'(i), m_acc[i], "acc_model");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_acc[i] = 16'h0;
    m_selb = 16'h0; m_vld = 1'b0; m_z = 1'b0; m_n = 1'b0;

    // Power-on reset
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'b11, 1'b0, 1'b0, 11'h0, 16'h0, 16'h0);
    tick(); tick();

    // Random writes, then a 2-cycle reset must clear everything
    for (int k = 0; k < 10; k++) begin
      set_in(1'b0, 1'b1, 1'b0, 2'($urandom_range(3)), 2'($urandom_range(3)),
             2'($urandom_range(2)), 1'($urandom), 1'b1, 11'($urandom),
             16'($urandom | 1), 16'($urandom | 1));
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'b11, 1'b0, 1'b0, 11'h0, 16'h0, 16'h0);
    tick(); tick();
    for (int i = 0; i < 4; i++) chk_acc(2'(i), 16'h0, "reset_acc");
    chk("reset_valid", {15'h0, o_valid}, 16'h0);
    chk("reset_zero", {15'h0, o_zero}, 16'h0);
    chk("reset_neg", {15'h0, o_neg}, 16'h0);

    // Sign extension of the immediate
    set_in(1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 2'b01, 1'b1, 1'b1, 11'h7FF, 16'h0, 16'h0);
    tick();
    chk_acc(2'd2, 16'hFFFF, "ext_neg_acc");
    chk("ext_neg_flag", {15'h0, o_neg}, 16'h1);
    chk("ext_neg_zero", {15'h0, o_zero}, 16'h0);
    chk("ext_selb", o_SelB, 16'hFFFF);
    set_in(1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 2'b01, 1'b1, 1'b1, 11'h3FF, 16'h0, 16'h0);
    tick();
    chk_acc(2'd2, 16'h03FF, "ext_pos_acc");
    chk("ext_pos_flag", {15'h0, o_neg}, 16'h0);

    // ALU source writing zero, then SelA=11 holds acc and flags
    set_in(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'b10, 1'b0, 1'b1, 11'h0, 16'h0, 16'h0000);
    tick();
    chk("alu_zero", {15'h0, o_zero}, 16'h1);
    set_in(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'b11, 1'b0, 1'b1, 11'h0, 16'h1234, 16'h0);
    tick();
    chk_acc(2'd1, 16'h0000, "hold_acc");
    chk("hold_zero", {15'h0, o_zero}, 16'h1);

    // WrAcc without valid performs no write
    set_in(1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'b00, 1'b0, 1'b1, 11'h0, 16'h7777, 16'h0);
    tick();
    chk_acc(2'd1, 16'h0000, "novalid_acc");

    // Operand B issue, then a 3-cycle stall with new inputs freezes all state
    set_in(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'b11, 1'b0, 1'b0, 11'h0, 16'hABCD, 16'h0);
    tick();
    chk("stall_pre_selb", o_SelB, 16'hABCD);
    chk("stall_pre_valid", {15'h0, o_valid}, 16'h1);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 2'(k), 2'(k), 2'b00, 1'b0, 1'b1, 11'h0, 16'h1111 * 16'(k + 2), 16'h0);
      tick();
    end
    chk("stall_selb", o_SelB, 16'hABCD);
    chk("stall_valid", {15'h0, o_valid}, 16'h1);
    chk_acc(2'd0, 16'hABCD ^ 16'hABCD, "stall_acc0");
    chk_acc(2'd2, 16'h03FF, "stall_acc2");

    // Same-index write/read: forwarded with bypass, old value without
    set_in(1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 2'b00, 1'b0, 1'b1, 11'h0, 16'h1234, 16'h0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 2'b00, 1'b0, 1'b1, 11'h0, 16'h5555, 16'h0);
    #2;
`ifdef ACC_BYPASS_EN
    chk("bypass_same", o_ACC, 16'h5555);
`else
    chk("bypass_same", o_ACC, 16'h1234);
`endif
    tick();
    chk_acc(2'd3, 16'h5555, "bypass_next");

    // Reset with a stalled write pending clears everything, no write lands
    set_in(1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 2'b00, 1'b0, 1'b1, 11'h0, 16'h9999, 16'h0);
    tick();
    for (int i = 0; i < 4; i++) chk_acc(2'(i), 16'h0, "midrst_acc");
    chk("midrst_selb", o_SelB, 16'h0);
    chk("midrst_valid", {15'h0, o_valid}, 16'h0);

    // Random traffic with stalls against the model and scoreboard
    for (int k = 0; k < 200; k++) begin
      set_in(1'b0, 1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0),
             2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)),
             1'($urandom), 1'($urandom), 11'($urandom), 16'($urandom), 16'($urandom));
      tick();
    end
    idle();
    tick();
    chk_all_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bip_acc_bank.md
Name: bip_acc_bank

Overview:
Registered accumulator bank and operand-B pipeline stage for the BIP datapath. It replaces the combinational ACC/SelB selection with NUM_ACC clocked accumulators, built-in operand sign extension, an issue/stall handshake and registered Z/N flags. It sits between the decoder/control unit, the data memory and the ALU.

Parameters:
NBITS_D, 16, data/accumulator width
NBITS_O, 11, immediate operand width (sign-extended to NBITS_D internally); must be <= NBITS_D
NUM_ACC, 4, number of accumulators; power of 2, >= 2
IDX_W, 2, accumulator index width, = log2(NUM_ACC)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  reset
i_valid  in  1  instruction issued this cycle
i_stall  in  1  downstream stall; freezes all state
i_wr_idx  in  IDX_W  accumulator written
i_rd_idx  in  IDX_W  accumulator read on o_ACC
i_SelA  in  2  ACC source: 00 i_OutData, 01 sign-ext operand, 10 i_ALU, 11 hold
i_SelB  in  1  B source: 0 i_OutData, 1 sign-ext operand
i_WrAcc  in  1  accumulator write enable
i_Operand  in  NBITS_O  immediate operand
i_OutData  in  NBITS_D  data memory read data
i_ALU  in  NBITS_D  ALU result
o_ACC  out  NBITS_D  accumulator[i_rd_idx]
o_SelB  out  NBITS_D  registered operand B
o_valid  out  1  o_SelB valid
o_zero  out  1  last written value == 0
o_neg  out  1  MSB of last written value

Behaviour:
- Reset: synchronous, active-high (i_reset). On the reset edge, all accumulators, o_SelB, o_valid, o_zero and o_neg are set to 0. Reset has priority over i_stall and i_valid. Reset asserted mid-stall clears everything; the stalled entry is lost.
- Sign extension: ext = {{(NBITS_D-NBITS_O){i_Operand[NBITS_O-1]}}, i_Operand}.
- Write condition: we = i_valid & i_WrAcc & ~i_stall & (i_SelA != 2'b11).
  - When we is true, acc[i_wr_idx] takes the selected source at the clock edge (1-cycle latency).
  - SelA = 11 never writes and leaves the flags unchanged.
- Flags: updated only when we is true. o_zero = (wdata == 0), o_neg = wdata[NBITS_D-1]. Otherwise held.
- Operand-B stage:
  - If ~i_stall: o_SelB <= i_valid ? selected B : o_SelB (value held when not valid); o_valid <= i_valid.
  - If i_stall: o_SelB and o_valid are held unchanged, and i_valid is ignored (the control unit must re-present the instruction).
- Read port: o_ACC = acc[i_rd_idx], combinational from the register array. Without bypass, a write shows on o_ACC the cycle after the edge.
- Simultaneous events: a write and a read of different indices are independent. A same-index write and read returns the old value (see the optional feature). i_WrAcc without i_valid performs no write.
- Index range: always in range, since NUM_ACC is a power of 2; no wrap logic is needed.

Optional Feature:
Macro ACC_BYPASS_EN.
- Defined: when we is true and i_rd_idx == i_wr_idx, o_ACC returns wdata in the same cycle (write-through forwarding). Otherwise o_ACC = acc[i_rd_idx].
- Undefined: no forwarding; o_ACC always shows the stored register value.

Test Plan:
- Reset: hold i_reset 2 cycles after random writes -> all acc read 0 on every i_rd_idx; o_valid = 0, o_zero = 0, o_neg = 0.
- Sign extension: i_valid=1, i_WrAcc=1, i_SelA=01, i_wr_idx=2, i_Operand=11'h7FF -> after edge acc[2]=16'hFFFF, o_neg=1, o_zero=0. Then i_Operand=11'h3FF -> acc[2]=16'h03FF, o_neg=0.
- Source mux and hold: write i_ALU=16'h0000 via SelA=10 to acc[1] -> o_zero=1. Next cycle SelA=11 with i_OutData=16'h1234 -> acc[1] stays 0 and o_zero stays 1.
- Stall: i_SelB=0, i_OutData=16'hABCD, i_valid=1 -> next cycle o_SelB=16'hABCD, o_valid=1. Then assert i_stall 3 cycles with new inputs and SelA=00 writes -> o_SelB, o_valid and all acc unchanged.
- Bypass: write acc[3] <= 16'h5555 while i_rd_idx=3 -> same cycle o_ACC=16'h5555 with ACC_BYPASS_EN, old value without it. Both builds show 16'h5555 on the next cycle.
- Reset mid-operation: i_reset together with i_valid=1, i_WrAcc=1, i_stall=1 -> all state 0 after the edge; no write occurs.
